// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer
//   On-chip run controller for a Bambu-generated HLS core. Launches the core
//   cfg_num_runs times through the start_port/done_port handshake. Each run is
//   preceded by a RST_CYCLES-long core reset. The controller times every run
//   against an optional watchdog and streams one result per run through a
//   valid/ready port. It also keeps min/max/total statistics over runs that
//   finished OK.
//
// Ports
//   clock, reset     : single rising-edge clock, synchronous active-high reset
//   cfg_start        : 1-cycle batch request, ignored while busy
//   cfg_num_runs     : runs in the batch, sampled with an accepted cfg_start
//   cfg_timeout      : per-run watchdog limit in cycles (0 disables it)
//   abort            : ends the current batch immediately
//   dut_reset        : reset to the HLS core (active-high)
//   dut_start_port   : 1-cycle launch pulse to the core
//   dut_done_port    : completion pulse from the core (only observed in WAIT)
//   busy             : batch in progress
//   all_done         : 1-cycle pulse at the end of a batch (normal or aborted)
//   aborted          : sticky flag, the last batch was aborted
//   res_valid/ready  : per-run result handshake
//   res_run_idx      : 0-based run index of the pending result
//   res_cycles       : measured cycles (start cycle to done cycle, inclusive)
//   res_status       : 00 OK, 01 TIMEOUT
//   stat_min/max     : min/max res_cycles over OK runs
//   stat_total       : saturating sum of res_cycles over OK runs
module hls_run_sequencer #(
    parameter int CYC_W      = 32,
    parameter int RUN_W      = 16,
    parameter int STAT_W     = 48,
    parameter int RST_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [RUN_W-1:0]  cfg_num_runs,
    input  logic [CYC_W-1:0]  cfg_timeout,
    input  logic              abort,
    output logic              dut_reset,
    output logic              dut_start_port,
    input  logic              dut_done_port,
    output logic              busy,
    output logic              all_done,
    output logic              aborted,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RUN_W-1:0]  res_run_idx,
    output logic [CYC_W-1:0]  res_cycles,
    output logic [1:0]        res_status,
    output logic [CYC_W-1:0]  stat_min,
    output logic [CYC_W-1:0]  stat_max,
    output logic [STAT_W-1:0] stat_total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DUT,
        S_LAUNCH,
        S_WAIT,
        S_REPORT,
        S_FINISH
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;

    localparam int RC_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    state_t             state_q, state_d;
    logic [RC_W-1:0]    rst_cnt_q;
    logic [RUN_W-1:0]   num_runs_q;
    logic [CYC_W-1:0]   timeout_q;
    logic [CYC_W-1:0]   cnt_q;
    logic [RUN_W-1:0]   idx_q;
    logic [CYC_W-1:0]   cycles_q;
    logic [1:0]         status_q;
    logic               aborted_q;
    logic [CYC_W-1:0]   min_q, max_q;
    logic [STAT_W-1:0]  total_q;

    logic [CYC_W:0]     cnt_inc;
    logic [CYC_W-1:0]   cnt_inc_sat;
    logic               timed_out;
    logic               last_run;
    logic               abort_take;
    logic [STAT_W:0]    total_sum;
    logic [STAT_W-1:0]  total_next;

    // Counter arithmetic is done one bit wider so both the watchdog compare
    // and the saturation see the true cnt+1.
    assign cnt_inc     = {1'b0, cnt_q} + {{CYC_W{1'b0}}, 1'b1};
    assign cnt_inc_sat = cnt_inc[CYC_W] ? '1 : cnt_inc[CYC_W-1:0];
    assign timed_out   = (timeout_q != '0) && (cnt_inc >= {1'b0, timeout_q});
    assign last_run    = (idx_q + RUN_W'(1)) == num_runs_q;
    // A batch that is already finishing has nothing left to abort.
    assign abort_take  = abort && (state_q != S_IDLE) && (state_q != S_FINISH);
    assign total_sum   = {1'b0, total_q} + {{(STAT_W + 1 - CYC_W){1'b0}}, cycles_q};
    assign total_next  = total_sum[STAT_W] ? '1 : total_sum[STAT_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dut_reset      = reset;
        dut_start_port = 1'b0;
        busy           = 1'b0;
        all_done       = 1'b0;
        res_valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = (cfg_num_runs == '0) ? S_FINISH : S_RST_DUT;
                end
            end
            S_RST_DUT: begin
                busy      = 1'b1;
                dut_reset = 1'b1;
                if (rst_cnt_q == RC_LAST) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                busy           = 1'b1;
                dut_start_port = 1'b1;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (dut_done_port || timed_out) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = last_run ? S_FINISH : S_RST_DUT;
                end
            end
            S_FINISH: begin
                busy     = 1'b1;
                all_done = 1'b1;
                // aborted_q is only set here when this FINISH came from an
                // abort, so the core is held in reset for that cycle only.
                if (aborted_q) begin
                    dut_reset = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_take) begin
            state_d = S_FINISH;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt_q  <= '0;
            num_runs_q <= '0;
            timeout_q  <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            cycles_q   <= '0;
            status_q   <= ST_OK;
            aborted_q  <= 1'b0;
            min_q      <= '1;
            max_q      <= '0;
            total_q    <= '0;
        end else begin
            rst_cnt_q <= (state_q == S_RST_DUT) ? rst_cnt_q + RC_W'(1) : '0;

            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        num_runs_q <= cfg_num_runs;
                        timeout_q  <= cfg_timeout;
                        idx_q      <= '0;
                        cycles_q   <= '0;
                        status_q   <= ST_OK;
                        aborted_q  <= 1'b0;
                        min_q      <= '1;
                        max_q      <= '0;
                        total_q    <= '0;
                    end
                end
                S_LAUNCH: begin
                    cnt_q <= CYC_W'(1);
                end
                S_WAIT: begin
                    if (!abort_take) begin
                        // done has priority over a watchdog hit in the same cycle
                        if (dut_done_port) begin
                            cycles_q <= cnt_inc_sat;
                            status_q <= ST_OK;
                        end else if (timed_out) begin
                            cycles_q <= timeout_q;
                            status_q <= ST_TIMEOUT;
                        end else begin
                            cnt_q <= cnt_inc_sat;
                        end
                    end
                end
                S_REPORT: begin
                    if (res_ready && !abort_take) begin
                        idx_q <= idx_q + RUN_W'(1);
                        if (status_q == ST_OK) begin
                            if (cycles_q < min_q) begin
                                min_q <= cycles_q;
                            end
                            if (cycles_q > max_q) begin
                                max_q <= cycles_q;
                            end
                            total_q <= total_next;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (abort_take) begin
                aborted_q <= 1'b1;
            end
        end
    end

    assign aborted     = aborted_q;
    assign res_run_idx = idx_q;
    assign res_cycles  = cycles_q;
    assign res_status  = status_q;
    assign stat_min    = min_q;
    assign stat_max    = max_q;
    assign stat_total  = total_q;

endmodule
